dmem_arbiter: RTL

The data-memory arbiter sits between two requesters and the single-port 16-bit × 2048 data memory. Port 0 is the pipeline MEM stage (load/store/push/pop/CALL/RET). Port 1 is the interrupt unit (context save/restore). Each requester issues a one-word or two-word (32-bit) transaction, and the block grants requesters round-robin. It then sequences one memory beat per cycle and returns a one-cycle `done` pulse with the assembled read data.

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port data
// memory. Port 0 is the pipeline MEM stage and port 1 is the interrupt unit.
// Each granted transaction is one or two word beats, followed by a one-cycle
// Done pulse that carries the assembled read data on RData.
module dmem_arbiter #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Req0,
    input  logic            Req1,
    input  logic            We0,
    input  logic            We1,
    input  logic            Dbl0,
    input  logic            Dbl1,
    input  logic [AW-1:0]   Addr0,
    input  logic [AW-1:0]   Addr1,
    input  logic [2*DW-1:0] WData0,
    input  logic [2*DW-1:0] WData1,
    output logic            Done0,
    output logic            Done1,
    output logic [2*DW-1:0] RData,
    output logic            Busy,
    output logic            Gnt,
    output logic            MemWrite,
    output logic            MemRead,
    output logic [AW-1:0]   MemAddr,
    output logic [DW-1:0]   MemDataIn,
    input  logic [DW-1:0]   MemDataOut
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state, state_nxt;
    logic              we_q, dbl_q;
    logic [AW-1:0]     addr_q;
    logic [2*DW-1:0]   wdata_q;
    logic              gnt_q;
    logic              last_q;   // port granted most recently; breaks ties
    logic              win;

    // A lone requester wins; on a tie the port not served last time wins.
    assign win  = (Req0 && Req1) ? ~last_q : Req1;
    assign Gnt  = gnt_q;
    assign Busy = (state != IDLE);

    // State register; reset drops the strobes at once, aborting a pending write.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and memory-side / completion outputs, decoded from state.
    always_comb begin
        state_nxt = state;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        MemAddr   = '0;
        MemDataIn = '0;
        Done0     = 1'b0;
        Done1     = 1'b0;
        case (state)
            IDLE: begin
                if (Req0 || Req1) state_nxt = BEAT0;
            end
            BEAT0: begin
                MemAddr   = addr_q;
                MemWrite  = we_q;
                MemRead   = ~we_q;
                MemDataIn = dbl_q ? wdata_q[2*DW-1:DW] : wdata_q[DW-1:0];
                state_nxt = dbl_q ? BEAT1 : RESP;
            end
            BEAT1: begin
                // Second word wraps naturally at the top of the address space.
                MemAddr   = addr_q + AW'(1);
                MemWrite  = we_q;
                MemRead   = ~we_q;
                MemDataIn = wdata_q[DW-1:0];
                state_nxt = RESP;
            end
            RESP: begin
                Done0     = ~gnt_q;
                Done1     = gnt_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's request at grant so later input changes are ignored.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            we_q    <= 1'b0;
            dbl_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else if (state == IDLE && (Req0 || Req1)) begin
            we_q    <= win ? We1    : We0;
            dbl_q   <= win ? Dbl1   : Dbl0;
            addr_q  <= win ? Addr1  : Addr0;
            wdata_q <= win ? WData1 : WData0;
            gnt_q   <= win;
            last_q  <= win;
        end
    end

    // Read data capture at the edge closing each read beat; writes leave it alone.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            RData <= '0;
        end else if (!we_q) begin
            if (state == BEAT0) begin
                if (dbl_q) RData[2*DW-1:DW] <= MemDataOut;
                else       RData <= {{DW{1'b0}}, MemDataOut};
            end else if (state == BEAT1) begin
                RData[DW-1:0] <= MemDataOut;
            end
        end
    end

endmodule
